universal_shift_reg: RTL and testbench

Parametrised universal shift register for the Lab 8 register family. It extends plain parallel-in/parallel-out storage with parallel load, single-step shift, rotate and arithmetic shift, serial in/out on both ends, and a multi-cycle burst shift with busy/done handshake. It sits between a data source and any consumer that needs registered, shiftable words, such as serialisers or bit-scan logic.

---
 rtl/universal_shift_reg.sv | 183 ++++++++++++++++++
 tb/tb_universal_shift_reg.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parameterised shift register with parallel load,
// single-step shift/rotate/arithmetic-shift, serial ports on both ends and
// a multi-cycle burst shift with a busy/done handshake.

// One bit of the register. It selects the next value of this bit from the
// candidate words the top level builds for each mode.
module usr_bit_cell (
   input  logic       do_step,
   input  logic [2:0] mode,
   input  logic       cur,
   input  logic       load_b,
   input  logic       shl_b,
   input  logic       shr_b,
   input  logic       rol_b,
   input  logic       ror_b,
   input  logic       asr_b,
   output logic       nxt
);

   // Per-bit mode mux; HOLD and the reserved code keep the current value.
   always_comb begin
      nxt = cur;
      if (do_step) begin
         unique case (mode)
            3'b001:  nxt = load_b;
            3'b010:  nxt = shl_b;
            3'b011:  nxt = shr_b;
            3'b100:  nxt = rol_b;
            3'b101:  nxt = ror_b;
            3'b110:  nxt = asr_b;
            default: nxt = cur;
         endcase
      end
   end

endmodule

module universal_shift_reg #(
   parameter int WIDTH = 16,
   localparam int SW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [SW-1:0]    shamt,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_LOAD = 3'b001,
      M_SHL  = 3'b010,
      M_SHR  = 3'b011,
      M_ROL  = 3'b100,
      M_ROR  = 3'b101,
      M_ASR  = 3'b110,
      M_RSVD = 3'b111
   } mode_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e          state, state_nx;
   logic [SW-1:0]   cnt, cnt_nx;
   logic [2:0]      mode_r, mode_r_nx;
   logic            done_nx;
   logic            do_step;
   logic [2:0]      step_mode;
   logic            is_shift;

   logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v, asr_v, q_nx;

   // Candidate words for every shifting mode; serial inputs are used live.
   assign shl_v = {q[WIDTH-2:0], sin_r};
   assign shr_v = {sin_l, q[WIDTH-1:1]};
   assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
   assign ror_v = {q[0], q[WIDTH-1:1]};
   assign asr_v = {q[WIDTH-1], q[WIDTH-1:1]};

   // Modes that take part in a multi-cycle burst (SHL..ASR).
   assign is_shift = (mode >= M_SHL) && (mode <= M_ASR);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         usr_bit_cell u_cell (
            .do_step (do_step),
            .mode    (step_mode),
            .cur     (q[gi]),
            .load_b  (data_in[gi]),
            .shl_b   (shl_v[gi]),
            .shr_b   (shr_v[gi]),
            .rol_b   (rol_v[gi]),
            .ror_b   (ror_v[gi]),
            .asr_b   (asr_v[gi]),
            .nxt     (q_nx[gi])
         );
      end
   endgenerate

   // Next-state / step control. start outranks en in IDLE; RUN ignores
   // every control input and just replays the latched mode.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      mode_r_nx = mode_r;
      done_nx   = 1'b0;
      do_step   = 1'b0;
      step_mode = mode;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (shamt == '0) begin
                  // zero-length burst: no step, just acknowledge
                  done_nx = 1'b1;
               end else if (is_shift) begin
                  do_step   = 1'b1;
                  mode_r_nx = mode;
                  if (shamt == SW'(1)) begin
                     done_nx = 1'b1;
                  end else begin
                     cnt_nx   = shamt - SW'(1);
                     state_nx = S_RUN;
                  end
               end else begin
                  // HOLD / LOAD / reserved: a single step, acknowledged at once
                  do_step = 1'b1;
                  done_nx = 1'b1;
               end
            end else if (en) begin
               do_step = 1'b1;
            end
         end
         S_RUN: begin
            do_step   = 1'b1;
            step_mode = mode_r;
            cnt_nx    = cnt - SW'(1);
            if (cnt == SW'(1)) begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State, counter, latched mode and done pulse; reset aborts any burst.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mode_r <= M_HOLD;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         mode_r <= mode_r_nx;
         done   <= done_nx;
      end
   end

   // Data register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) q <= '0;
      else      q <= q_nx;
   end

   assign busy   = (state == S_RUN);
   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: each task queues per-cycle
// stimulus with the outputs expected after that edge, then drains it.
module tb_universal_shift_reg;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          clr;
   logic          en;
   logic [2:0]    mode;
   logic [W-1:0]  data_in;
   logic          sin_l, sin_r;
   logic          start;
   logic [3:0]    shamt;
   logic [W-1:0]  q;
   logic          sout_l, sout_r, busy, done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]   mode;
      logic         en, start, sin_l, sin_r;
      logic [W-1:0] din;
      logic [3:0]   shamt;
      logic [W-1:0] q;
      logic         busy, done;
   } cyc_t;

   typedef struct {
      logic [W-1:0] q;
      logic         busy, done;
   } exp_t;

   cyc_t plan[$];
   exp_t sb[$];

   universal_shift_reg #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .en(en), .mode(mode), .data_in(data_in),
      .sin_l(sin_l), .sin_r(sin_r), .start(start), .shamt(shamt),
      .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic void add(input logic [2:0] m, input logic e, input logic s,
                               input logic [W-1:0] d, input logic [3:0] sh,
                               input logic sl, input logic sr,
                               input logic [W-1:0] eq, input logic eb, input logic ed);
      cyc_t c;
      c.mode = m; c.en = e; c.start = s; c.din = d; c.shamt = sh;
      c.sin_l = sl; c.sin_r = sr; c.q = eq; c.busy = eb; c.done = ed;
      plan.push_back(c);
   endfunction

   // idle cycle: nothing driven, expected outputs given
   function automatic void idle(input logic [W-1:0] eq, input logic eb, input logic ed);
      add(3'b000, 1'b0, 1'b0, '0, 4'd0, 1'b0, 1'b0, eq, eb, ed);
   endfunction

   // single-step load
   function automatic void ld(input logic [W-1:0] d);
      add(3'b001, 1'b1, 1'b0, d, 4'd0, 1'b0, 1'b0, d, 1'b0, 1'b0);
   endfunction

   task automatic test_reset();
      clr = 1'b0; en = 0; mode = 0; data_in = 0; sin_l = 0; sin_r = 0;
      start = 0; shamt = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({q, busy, done, sout_l, sout_r} !== {16'h0000, 4'b0000}) begin
         failures++;
         $display("FAIL reset_hold: got q=%h busy=%b done=%b sl=%b sr=%b, want all zero",
                  q, busy, done, sout_l, sout_r);
      end
      clr = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({q, busy, done} !== {16'h0000, 2'b00}) begin
         failures++;
         $display("FAIL reset_release: got q=%h busy=%b done=%b, want 0000/0/0", q, busy, done);
      end
   endtask

   task automatic test_load();
      cyc_t c; exp_t e;
      ld(16'h0001);
      idle(16'h0001, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         mode = c.mode; en = c.en; start = c.start; data_in = c.din;
         shamt = c.shamt; sin_l = c.sin_l; sin_r = c.sin_r;
         sb.push_back('{q: c.q, busy: c.busy, done: c.done});
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if ({q, busy, done, sout_l, sout_r} !== {e.q, e.busy, e.done, e.q[W-1], e.q[0]}) begin
            failures++;
            $display("FAIL load: got q=%h busy=%b done=%b sl=%b sr=%b, want q=%h busy=%b done=%b",
                     q, busy, done, sout_l, sout_r, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_burst_rotate();
      cyc_t c; exp_t e;
      // ROL x4 from 0x0001
      add(3'b100, 0, 1, '0, 4'd4, 0, 0, 16'h0002, 1, 0);
      idle(16'h0004, 1, 0);
      idle(16'h0008, 1, 0);
      idle(16'h0010, 0, 1);
      idle(16'h0010, 0, 0);
      // ROR x15 from 0x0001 ends at 0x0002
      ld(16'h0001);
      add(3'b101, 0, 1, '0, 4'd15, 0, 0, 16'h8000, 1, 0);
      for (int k = 2; k <= 15; k++)
         idle(16'h0001 << (16 - k), (k < 15), (k == 15));
      idle(16'h0002, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         mode = c.mode; en = c.en; start = c.start; data_in = c.din;
         shamt = c.shamt; sin_l = c.sin_l; sin_r = c.sin_r;
         sb.push_back('{q: c.q, busy: c.busy, done: c.done});
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if ({q, busy, done, sout_l, sout_r} !== {e.q, e.busy, e.done, e.q[W-1], e.q[0]}) begin
            failures++;
            $display("FAIL burst_rotate: got q=%h busy=%b done=%b sl=%b sr=%b, want q=%h busy=%b done=%b",
                     q, busy, done, sout_l, sout_r, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_arith_serial();
      cyc_t c; exp_t e;
      // ASR burst x3 from 0x8000
      ld(16'h8000);
      add(3'b110, 0, 1, '0, 4'd3, 0, 0, 16'hC000, 1, 0);
      idle(16'hE000, 1, 0);
      idle(16'hF000, 0, 1);
      idle(16'hF000, 0, 0);
      // SHR single steps with sin_l=1 from 0
      ld(16'h0000);
      add(3'b011, 1, 0, '0, 4'd0, 1, 0, 16'h8000, 0, 0);
      add(3'b011, 1, 0, '0, 4'd0, 1, 0, 16'hC000, 0, 0);
      add(3'b011, 1, 0, '0, 4'd0, 1, 0, 16'hE000, 0, 0);
      add(3'b011, 1, 0, '0, 4'd0, 1, 0, 16'hF000, 0, 0);
      // SHL single step with sin_r=1 and en=0 hold
      add(3'b010, 1, 0, '0, 4'd0, 0, 1, 16'hE001, 0, 0);
      add(3'b010, 0, 0, '0, 4'd0, 0, 1, 16'hE001, 0, 0);
      // ROR single step; reserved mode acts as hold
      add(3'b101, 1, 0, '0, 4'd0, 0, 0, 16'hF000, 0, 0);
      add(3'b111, 1, 0, 16'h5555, 4'd0, 1, 1, 16'hF000, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         mode = c.mode; en = c.en; start = c.start; data_in = c.din;
         shamt = c.shamt; sin_l = c.sin_l; sin_r = c.sin_r;
         sb.push_back('{q: c.q, busy: c.busy, done: c.done});
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if ({q, busy, done, sout_l, sout_r} !== {e.q, e.busy, e.done, e.q[W-1], e.q[0]}) begin
            failures++;
            $display("FAIL arith_serial: got q=%h busy=%b done=%b sl=%b sr=%b, want q=%h busy=%b done=%b",
                     q, busy, done, sout_l, sout_r, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_reset_mid();
      cyc_t c; exp_t e;
      ld(16'h00FF);
      add(3'b010, 0, 1, '0, 4'd8, 0, 0, 16'h01FE, 1, 0);
      idle(16'h03FC, 1, 0);
      idle(16'h07F8, 1, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         mode = c.mode; en = c.en; start = c.start; data_in = c.din;
         shamt = c.shamt; sin_l = c.sin_l; sin_r = c.sin_r;
         sb.push_back('{q: c.q, busy: c.busy, done: c.done});
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            failures++;
            $display("FAIL reset_mid_pre: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     q, busy, done, e.q, e.busy, e.done);
         end
      end
      #2 clr = 1'b0;
      #1;
      checks++;
      if ({q, busy, done} !== {16'h0000, 2'b00}) begin
         failures++;
         $display("FAIL reset_mid_async: got q=%h busy=%b done=%b, want 0000/0/0", q, busy, done);
      end
      @(posedge clk); #1;
      clr = 1'b1;
      for (int i = 0; i < 8; i++) idle(16'h0000, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         mode = c.mode; en = c.en; start = c.start; data_in = c.din;
         shamt = c.shamt; sin_l = c.sin_l; sin_r = c.sin_r;
         sb.push_back('{q: c.q, busy: c.busy, done: c.done});
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            failures++;
            $display("FAIL reset_mid_after: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     q, busy, done, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_boundary_starts();
      cyc_t c; exp_t e;
      // shamt=0: no change, single done
      ld(16'h1234);
      add(3'b010, 0, 1, '0, 4'd0, 0, 1, 16'h1234, 0, 1);
      idle(16'h1234, 0, 0);
      // start with LOAD
      add(3'b001, 0, 1, 16'hABCD, 4'd1, 0, 0, 16'hABCD, 0, 1);
      idle(16'hABCD, 0, 0);
      // shamt=1 burst finishes in IDLE
      add(3'b010, 0, 1, '0, 4'd1, 0, 1, 16'h579B, 0, 1);
      idle(16'h579B, 0, 0);
      // start while busy is dropped
      ld(16'h0001);
      add(3'b100, 0, 1, '0, 4'd3, 0, 0, 16'h0002, 1, 0);
      add(3'b001, 1, 1, 16'hFFFF, 4'd7, 0, 0, 16'h0004, 1, 0);
      add(3'b011, 1, 1, 16'hFFFF, 4'd7, 1, 1, 16'h0008, 0, 1);
      idle(16'h0008, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         mode = c.mode; en = c.en; start = c.start; data_in = c.din;
         shamt = c.shamt; sin_l = c.sin_l; sin_r = c.sin_r;
         sb.push_back('{q: c.q, busy: c.busy, done: c.done});
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if ({q, busy, done, sout_l, sout_r} !== {e.q, e.busy, e.done, e.q[W-1], e.q[0]}) begin
            failures++;
            $display("FAIL boundary_starts: got q=%h busy=%b done=%b sl=%b sr=%b, want q=%h busy=%b done=%b",
                     q, busy, done, sout_l, sout_r, e.q, e.busy, e.done);
         end
      end
   endtask

   task automatic test_back_to_back();
      cyc_t c; exp_t e;
      // q=0x0008 from previous task
      add(3'b100, 0, 1, '0, 4'd2, 0, 0, 16'h0010, 1, 0);
      idle(16'h0020, 0, 1);
      add(3'b101, 0, 1, '0, 4'd2, 0, 0, 16'h0010, 1, 0);
      idle(16'h0008, 0, 1);
      idle(16'h0008, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         mode = c.mode; en = c.en; start = c.start; data_in = c.din;
         shamt = c.shamt; sin_l = c.sin_l; sin_r = c.sin_r;
         sb.push_back('{q: c.q, busy: c.busy, done: c.done});
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            failures++;
            $display("FAIL back_to_back: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     q, busy, done, e.q, e.busy, e.done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_burst_rotate();
      test_arith_serial();
      test_reset_mid();
      test_boundary_starts();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
